idli_uart_rx_m: RTL
===================

# idli_uart_rx_m

UART receiver for the idli core. It is the receive-side counterpart of the core's UART transmitter and fills the currently unconnected RX path of the top level. The block samples the asynchronous serial input and recovers 8N1 frames, buffering up to two bytes. It presents received data to the execute stage as a nibble-serial stream (low nibble first) with a valid/accept handshake, matching the core's 4-bit datapath.

## Interface
- CLKS_PER_BIT, default 16: core clocks per UART bit. Must be even and ≥ 4; elaboration fails otherwise.
- i_urx_gck  in  1  core clock; all state updates on its rising edge.
- i_urx_rst  in  1  synchronous, active-high reset.
- i_urx_rx  in  1  asynchronous serial line; idles high.
- o_urx_data  out  sqi_data_t (4)  current nibble of head byte; low nibble first.
- o_urx_vld  out  1  o_urx_data is valid.
- i_urx_acp  in  1  consumer takes the current nibble; ignored when o_urx_vld=0.
- o_urx_busy  out  1  frame reception in progress (FSM not in IDLE).
- o_urx_ovf  out  1  sticky: a complete byte was dropped because the FIFO was full.
- o_urx_ferr  out  1  sticky: a stop bit was sampled low.
- i_urx_clr  in  1  clears o_urx_ovf and o_urx_ferr.

## Operation
- Input synchroniser: two flops on i_urx_rx, both reset to 1. The FSM uses only the second stage (rxs).
- Bit counter: width $clog2(CLKS_PER_BIT), cleared on every state change. Bit index: 3 bits.
- FSM states and transitions:
  - IDLE: when rxs=0, go to START.
  - START: wait CLKS_PER_BIT/2 cycles, then sample rxs.
    - rxs=0: go to DATA, bit index 0.
    - rxs=1: treat as a glitch and return to IDLE with no flag.
  - DATA: wait CLKS_PER_BIT cycles, then sample rxs into the shift register, LSB first (shift right, insert at bit 7). After bit index 7, go to STOP.
  - STOP: wait CLKS_PER_BIT cycles, then sample rxs.
    - rxs=1: push the byte and go to IDLE.
    - rxs=0: set ferr, discard the byte, go to BREAK.
  - BREAK: stay until rxs=1, then go to IDLE. A held-low line therefore produces exactly one ferr and no data.
- FIFO: 2 entries × 8 bits, plus a nibble-select bit ns on the head entry.
  - o_urx_vld = FIFO not empty.
  - o_urx_data = ns ? head[7:4] : head[3:0].
  - Accept with ns=0: ns←1.
  - Accept with ns=1: pop the head, ns←0.
- Push when full:
  - If the head is popped in the same cycle, the push succeeds.
  - Otherwise the new byte is dropped and ovf is set. FIFO contents are unchanged.
- Sticky flags: i_urx_clr clears both. If a flag is set and cleared in the same cycle, the set wins.
- Reset mid-frame: the partial frame is discarded, the FIFO is emptied, and the FSM restarts in IDLE. A line still low after reset is treated as a new start edge.

## Timing
- Reset values of all outputs: o_urx_data=0, o_urx_vld=0, o_urx_busy=0, o_urx_ovf=0, o_urx_ferr=0.
- Cycle 0 is the edge at which synchroniser stage 1 first captures 0. o_urx_vld for that frame rises exactly 9·CLKS_PER_BIT + CLKS_PER_BIT/2 + 3 cycles after cycle 0, provided the FIFO is not full.
- Handshake:
  - Each cycle with o_urx_vld & i_urx_acp consumes one nibble.
  - A byte drains in 2 accepting cycles. A back-to-back second byte is visible the cycle after the pop.
  - o_urx_data is stable while o_urx_vld=1 and i_urx_acp=0.
- o_urx_busy rises one cycle after cycle 1 (when START is entered) and falls on entry to IDLE.
- Sampling is at mid-bit. The stop-bit sample is half a bit before the frame's true end, which allows resynchronisation to back-to-back frames.

## Structure
- Add to idli_pkg:
  - urx_state_t enum: IDLE, START, DATA, STOP, BREAK.
  - URX_FIFO_DEPTH = 2.
- One sub-module, idli_urx_fifo_m: 2-entry byte FIFO with nibble-select and nibble-serial read port, and push/full/empty signals. The FSM, synchroniser and flags live in idli_uart_rx_m.

## Test plan
All cases use CLKS_PER_BIT=8.
1. Send 0xA5 (8N1), no backpressure → o_urx_vld rises 79 cycles after cycle 0. Nibbles 0x5 then 0xA are accepted. Flags stay 0.
2. Line low for 3 cycles, then high (glitch) → FSM returns to IDLE. o_urx_vld, o_urx_ovf and o_urx_ferr stay 0.
3. Frame 0x3C with stop bit low, line held low for 40 cycles → o_urx_ferr=1 set once, no data pushed. The next valid 0x12 is received. A pulse on i_urx_clr clears ferr.
4. Three back-to-back frames 0x11, 0x22, 0x33 with i_urx_acp=0 → FIFO holds 0x11 and 0x22, o_urx_ovf=1. Draining yields nibbles 1,1,2,2.
5. FIFO full, with the final head-nibble accept on the same cycle as a push → no overflow. The new byte follows.
6. Assert i_urx_rst during data bit 4 of a frame → outputs return to reset values the next cycle. The FIFO is empty and the FSM is in IDLE.

Source files
------------

// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core.
// Holds the nibble datapath type and the UART receiver state encoding.
package idli_pkg;

    typedef logic [3:0] sqi_data_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } urx_state_t;

    localparam int unsigned URX_FIFO_DEPTH = 2;

endpackage

// File: rtl/idli_urx_fifo_m.sv
// Small byte FIFO for the UART receiver with a nibble-serial read port.
// The head byte is read low nibble first; it is popped on the second accept.
module idli_urx_fifo_m
    import idli_pkg::*;
(
    input  logic       i_fifo_gck,
    input  logic       i_fifo_rst,
    input  logic       i_fifo_push,
    input  logic [7:0] i_fifo_data,
    input  logic       i_fifo_acp,
    output sqi_data_t  o_fifo_data,
    output logic       o_fifo_empty,
    output logic       o_fifo_full,
    output logic       o_fifo_pop
);

    // Pointers wrap naturally, so the depth must stay a power of two.
    localparam int unsigned PtrW = (URX_FIFO_DEPTH > 1) ? $clog2(URX_FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(URX_FIFO_DEPTH + 1);

    logic [7:0]      mem_q [URX_FIFO_DEPTH];
    logic [7:0]      mem_d [URX_FIFO_DEPTH];
    logic [PtrW-1:0] rd_q, rd_d;
    logic [PtrW-1:0] wr_q, wr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ns_q, ns_d;
    logic            acc;
    logic            wr_en;
    logic [7:0]      head;

    assign o_fifo_empty = (cnt_q == '0);
    assign o_fifo_full  = (cnt_q == CntW'(URX_FIFO_DEPTH));
    assign head         = mem_q[rd_q];

    always_comb begin
        acc        = !o_fifo_empty && i_fifo_acp;
        o_fifo_pop = acc && ns_q;
        // A pop in the same cycle frees the slot the push needs.
        wr_en      = i_fifo_push && (!o_fifo_full || o_fifo_pop);

        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_q] = i_fifo_data;
        end

        rd_d  = rd_q + PtrW'(o_fifo_pop);
        wr_d  = wr_q + PtrW'(wr_en);
        cnt_d = cnt_q + CntW'(wr_en) - CntW'(o_fifo_pop);
        ns_d  = acc ? !ns_q : ns_q;

        if (o_fifo_empty) begin
            o_fifo_data = '0;
        end else begin
            o_fifo_data = ns_q ? head[7:4] : head[3:0];
        end
    end

    always_ff @(posedge i_fifo_gck) begin
        if (i_fifo_rst) begin
            mem_q <= '{default: '0};
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            ns_q  <= 1'b0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            ns_q  <= ns_d;
        end
    end

endmodule

// File: rtl/idli_uart_rx_m.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling FSM and sticky error flags.
// Received bytes go through a two-entry FIFO and leave as a nibble stream.
module idli_uart_rx_m
    import idli_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic      i_urx_gck,
    input  logic      i_urx_rst,
    input  logic      i_urx_rx,
    output sqi_data_t o_urx_data,
    output logic      o_urx_vld,
    input  logic      i_urx_acp,
    output logic      o_urx_busy,
    output logic      o_urx_ovf,
    output logic      o_urx_ferr,
    input  logic      i_urx_clr
);

    if ((CLKS_PER_BIT % 2 != 0) || (CLKS_PER_BIT < 4)) begin : g_bad_clks_per_bit
        $error("CLKS_PER_BIT must be even and at least 4");
    end

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

    urx_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            push_q, push_d;
    logic            ferr_q, ferr_d;
    logic            ovf_q, ovf_d;
    logic            rx_s1_q;
    logic            rxs_q;
    logic            ferr_set;
    logic            fifo_empty;
    logic            fifo_full;
    logic            fifo_pop;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CntW'(1);
        idx_d    = idx_q;
        shift_d  = shift_q;
        push_d   = 1'b0;
        ferr_set = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CntHalf) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = rxs_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        push_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold here until the line recovers so a long low reports once.
                cnt_d = '0;
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        ferr_d = ferr_set || (ferr_q && !i_urx_clr);
        ovf_d  = (push_q && fifo_full && !fifo_pop) || (ovf_q && !i_urx_clr);
    end

    always_ff @(posedge i_urx_gck) begin
        if (i_urx_rst) begin
            rx_s1_q <= 1'b1;
            rxs_q   <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            rx_s1_q <= i_urx_rx;
            rxs_q   <= rx_s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            push_q  <= push_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
        end
    end

    idli_urx_fifo_m u_fifo (
        .i_fifo_gck   (i_urx_gck),
        .i_fifo_rst   (i_urx_rst),
        .i_fifo_push  (push_q),
        .i_fifo_data  (shift_q),
        .i_fifo_acp   (i_urx_acp),
        .o_fifo_data  (o_urx_data),
        .o_fifo_empty (fifo_empty),
        .o_fifo_full  (fifo_full),
        .o_fifo_pop   (fifo_pop)
    );

    assign o_urx_vld  = !fifo_empty;
    assign o_urx_busy = (state_q != IDLE);
    assign o_urx_ferr = ferr_q;
    assign o_urx_ovf  = ovf_q;

endmodule
